snake_step_controller: RTL and testbench
========================================

# snake_step_controller

Sequences one game step of the snake per `tick`. Each step runs in two phases against the combinational collision detector. First it probes for a wall hit from the current head. Then it probes the candidate next head for self-hit and food. It then commits the move: body shift, growth, and food-respawn handshake with the food spawner. It owns the snake state registers, which are the source of `snake_body_flat`, `snake_length` and `food_pos` for the detector and the renderer.

## Interface
- `MAX_LEN`, 64: body slot count; slot 0 = head
- `POS_BITS`, 13: linear cell index width (idx = y*GRID_W + x)
- `GRID_W`, 100: grid columns
- `GRID_H`, 75: grid rows
- `START_POS`, 3750: head cell after reset/start
- `FOOD_INIT`, 3760: food cell after reset/start

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  level; leaves IDLE/OVER
- `tick`  in  1  one-cycle step strobe
- `dir_req`  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- `pause`  in  1  freeze request; used only with PAUSE_EN
- `det_collision`  in  1  detector collision result, same cycle
- `det_food_eaten`  in  1  detector food result, same cycle
- `spawn_valid`  in  1  new food position valid
- `spawn_pos`  in  POS_BITS  new food position
- `det_head`  out  POS_BITS  head presented to detector
- `det_dir`  out  2  direction presented to detector
- `snake_head`  out  POS_BITS  committed head (= slot 0)
- `snake_body_flat`  out  MAX_LEN*POS_BITS  slot i at [i*POS_BITS +: POS_BITS]
- `snake_length`  out  7  live slots, 1..MAX_LEN
- `food_pos`  out  POS_BITS  current food cell
- `spawn_req`  out  1  held high until `spawn_valid`
- `busy`  out  1  high in any state other than IDLE, RUN, OVER
- `game_over`  out  1  high in OVER
- `score`  out  7  `snake_length` - 1

## Operation
- States: IDLE, RUN, PROBE_WALL, PROBE_BODY, UPDATE, WAIT_FOOD, OVER.
- Reset values:
  - state = IDLE.
  - Body slots all 0, except slot 0 = START_POS.
  - `snake_length` = 1; `food_pos` = FOOD_INIT; `dir` = 01.
  - `spawn_req`, `busy`, `game_over` = 0.
- IDLE: on `start`, go to RUN.
- OVER: on `start`, reload the reset values of the snake state and go to RUN.
- RUN: latch `dir_req` into `dir` every cycle, except:
  - a request opposite to `dir` is ignored when `snake_length` > 1.
- RUN, on `tick`: go to PROBE_WALL.
- PROBE_WALL: `det_head` = `snake_head`, `det_dir` = `dir`.
  - `det_collision` = 1: go to OVER.
  - otherwise: compute `next_head` and go to PROBE_BODY.
- `next_head` arithmetic: up = head − GRID_W, down = head + GRID_W, left = head − 1, right = head + 1.
  - Computed only after the wall probe passes, so no underflow or overflow.
- PROBE_BODY: `det_head` = `next_head`, `det_dir` = reverse of `dir`.
  - The reverse direction points back at the old head, which is always in-grid, so a wall hit can never fire here.
  - The body bus presents the old, unshifted body.
  - `det_collision` = 1: go to OVER. Entering the cell the tail is vacating counts as a collision.
  - `det_collision` = 0: latch `det_food_eaten` into `grow`, then go to UPDATE.
- UPDATE:
  - slot[i] ← slot[i−1] for i ≥ 1; slot 0 ← `next_head`.
  - If `grow` and `snake_length` < MAX_LEN: `snake_length` += 1.
  - At MAX_LEN, food is still consumed but length saturates.
  - If `grow`: assert `spawn_req` and go to WAIT_FOOD; else go to RUN.
- WAIT_FOOD: on `spawn_valid` (sampled while `spawn_req` = 1):
  - `food_pos` ← `spawn_pos`; drop `spawn_req` the next cycle; go to RUN.
  - Avoiding occupied cells is the spawner's job.
- Outside PROBE_*: `det_head` = `snake_head`, `det_dir` = `dir`.
- Slots at index ≥ `snake_length` hold stale data; the detector and renderer ignore them.

## Timing
- `tick` at cycle T (in RUN): PROBE_WALL at T+1, PROBE_BODY at T+2, UPDATE at T+3.
- New body visible at T+4; RUN at T+4 if no food.
- `tick` arriving in any state other than RUN is dropped; no queuing.
- `spawn_valid` may arrive any number of cycles after `spawn_req`, including the first WAIT_FOOD cycle.
- `rst` mid-step, including in WAIT_FOOD, overrides everything: reset values on the next edge.
- `start` and `tick` in the same cycle in IDLE: only the transition to RUN happens; the tick is dropped.

## Configuration
- `SNAKE_PAUSE_EN` defined:
  - In RUN, `pause` = 1 blocks `tick` and freezes `dir` latching.
  - A step already in progress completes.
  - `busy` stays 0 while paused.
- `SNAKE_PAUSE_EN` undefined: `pause` is ignored and no pause logic is synthesized.

## Test plan
- Reset, then `start`, then `tick` with `dir_req` = 01 and detector returning 0/0 -> at T+4: `snake_head` = 3751, `snake_length` = 1, `busy` = 0.
- Head 3760 = `food_pos`, `det_food_eaten` = 1 in PROBE_BODY -> `snake_length` 1→2, `spawn_req` = 1; `spawn_valid` with `spawn_pos` = 500 after 3 cycles -> `food_pos` = 500, RUN, `spawn_req` = 0.
- Head 10, `dir` = 00, `det_collision` = 1 in PROBE_WALL -> OVER at T+2, `game_over` = 1, body unchanged; subsequent `start` -> head 3750, length 1.
- Length 4 moving right, `dir_req` = 11 -> ignored, `dir` stays 01; `dir_req` = 00 -> accepted, next step head − 100.
- `det_collision` = 1 only in PROBE_BODY -> OVER; `det_head` was `next_head` and `det_dir` was the reverse direction during that cycle.
- `rst` asserted in WAIT_FOOD -> next cycle IDLE, `spawn_req` = 0, length 1; with `SNAKE_PAUSE_EN`, `pause` = 1 plus `tick` in RUN -> no step, `busy` = 0.

Source files
------------

// File: rtl/snake_step_controller.sv
// snake_step_controller
//
// Runs one snake game step per tick in two probe phases against an external
// combinational collision detector, then commits the move. It owns the snake
// state (body slots, length, food cell, direction), which the detector and the
// renderer read.
//
//   PROBE_WALL : detector sees the current head and the current direction
//   PROBE_BODY : detector sees the candidate head and the reverse direction
//   UPDATE     : body shift, optional growth, food-respawn request
//   WAIT_FOOD  : holds spawn_req until the spawner answers with spawn_valid
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             level; leaves IDLE or OVER (OVER also reloads state)
//   tick              one-cycle step strobe, honoured only in RUN
//   dir_req           requested direction: 00 up, 01 right, 10 down, 11 left
//   pause             freeze request (only with SNAKE_PAUSE_EN)
//   det_collision     detector collision result, same cycle
//   det_food_eaten    detector food result, same cycle
//   spawn_valid/pos   new food position from the spawner
//   det_head/det_dir  head and direction presented to the detector
//   snake_head        committed head (slot 0)
//   snake_body_flat   slot i at [i*POS_BITS +: POS_BITS]
//   snake_length      live slots, 1..MAX_LEN
//   food_pos          current food cell
//   spawn_req         held high until spawn_valid
//   busy              high while a step is in progress
//   game_over         high in OVER
//   score             snake_length - 1
//
// Build option
//   SNAKE_PAUSE_EN    when defined, pause blocks tick and direction latching
//                     in RUN; otherwise pause is ignored.

module snake_step_controller #(
    parameter int MAX_LEN   = 64,
    parameter int POS_BITS  = 13,
    parameter int GRID_W    = 100,
    parameter int GRID_H    = 75,
    parameter int START_POS = 3750,
    parameter int FOOD_INIT = 3760
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         tick,
    input  logic [1:0]                   dir_req,
    input  logic                         pause,
    input  logic                         det_collision,
    input  logic                         det_food_eaten,
    input  logic                         spawn_valid,
    input  logic [POS_BITS-1:0]          spawn_pos,
    output logic [POS_BITS-1:0]          det_head,
    output logic [1:0]                   det_dir,
    output logic [POS_BITS-1:0]          snake_head,
    output logic [MAX_LEN*POS_BITS-1:0]  snake_body_flat,
    output logic [6:0]                   snake_length,
    output logic [POS_BITS-1:0]          food_pos,
    output logic                         spawn_req,
    output logic                         busy,
    output logic                         game_over,
    output logic [6:0]                   score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PROBE_WALL,
        S_PROBE_BODY,
        S_UPDATE,
        S_WAIT_FOOD,
        S_OVER
    } state_t;

    localparam logic [6:0]          MAX_LEN_L   = 7'(MAX_LEN);
    localparam logic [POS_BITS-1:0] START_L     = POS_BITS'(START_POS);
    localparam logic [POS_BITS-1:0] FOOD_L      = POS_BITS'(FOOD_INIT);
    localparam logic [POS_BITS-1:0] ROW_STEP    = POS_BITS'(GRID_W);
    localparam logic [POS_BITS-1:0] COL_STEP    = POS_BITS'(1);
    // Grid height only matters to the detector's wall test.
    localparam int                  unused_grid_cells = GRID_W * GRID_H;

    state_t                state_q;
    logic [1:0]            dir_q;
    logic [POS_BITS-1:0]   body_q [MAX_LEN];
    logic [6:0]            len_q;
    logic [POS_BITS-1:0]   food_q;
    logic [POS_BITS-1:0]   next_head_q;
    logic [POS_BITS-1:0]   next_head_d;
    logic                  grow_q;
    logic                  spawn_req_q;
    logic                  busy_q;
    logic                  over_q;
    logic                  run_hold;
    logic                  dir_reject;

`ifdef SNAKE_PAUSE_EN
    assign run_hold = pause;
`else
    logic pause_unused;
    assign pause_unused = pause;
    assign run_hold     = 1'b0;
`endif

    // Reversal onto the own neck is refused once there is a neck.
    assign dir_reject = (len_q > 7'd1) && (dir_req == (dir_q ^ 2'b10));

    // Only consumed after the wall probe has cleared, so no wrap can occur.
    always_comb begin
        next_head_d = body_q[0];
        case (dir_q)
            2'b00:   next_head_d = body_q[0] - ROW_STEP;
            2'b01:   next_head_d = body_q[0] + COL_STEP;
            2'b10:   next_head_d = body_q[0] + ROW_STEP;
            default: next_head_d = body_q[0] - COL_STEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int unsigned i = 0; i < MAX_LEN; i++) body_q[i] <= '0;
            body_q[0]   <= START_L;
            len_q       <= 7'd1;
            food_q      <= FOOD_L;
            dir_q       <= 2'b01;
            next_head_q <= '0;
            grow_q      <= 1'b0;
            spawn_req_q <= 1'b0;
            busy_q      <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_RUN;
                end

                S_RUN: begin
                    if (!run_hold) begin
                        if (!dir_reject) dir_q <= dir_req;
                        if (tick) begin
                            state_q <= S_PROBE_WALL;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                S_PROBE_WALL: begin
                    if (det_collision) begin
                        state_q <= S_OVER;
                        busy_q  <= 1'b0;
                        over_q  <= 1'b1;
                    end else begin
                        next_head_q <= next_head_d;
                        state_q     <= S_PROBE_BODY;
                    end
                end

                S_PROBE_BODY: begin
                    if (det_collision) begin
                        state_q <= S_OVER;
                        busy_q  <= 1'b0;
                        over_q  <= 1'b1;
                    end else begin
                        grow_q  <= det_food_eaten;
                        state_q <= S_UPDATE;
                    end
                end

                S_UPDATE: begin
                    for (int unsigned i = 1; i < MAX_LEN; i++) body_q[i] <= body_q[i-1];
                    body_q[0] <= next_head_q;
                    if (grow_q) begin
                        // Food at full length is eaten without growing.
                        if (len_q < MAX_LEN_L) len_q <= len_q + 7'd1;
                        spawn_req_q <= 1'b1;
                        state_q     <= S_WAIT_FOOD;
                    end else begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b0;
                    end
                end

                S_WAIT_FOOD: begin
                    if (spawn_valid && spawn_req_q) begin
                        food_q      <= spawn_pos;
                        spawn_req_q <= 1'b0;
                        state_q     <= S_RUN;
                        busy_q      <= 1'b0;
                    end
                end

                S_OVER: begin
                    if (start) begin
                        for (int unsigned i = 0; i < MAX_LEN; i++) body_q[i] <= '0;
                        body_q[0]   <= START_L;
                        len_q       <= 7'd1;
                        food_q      <= FOOD_L;
                        dir_q       <= 2'b01;
                        grow_q      <= 1'b0;
                        spawn_req_q <= 1'b0;
                        over_q      <= 1'b0;
                        state_q     <= S_RUN;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The body probe looks back along the move so the old head, which is
    // always in-grid, is what the wall test sees.
    always_comb begin
        det_head = body_q[0];
        det_dir  = dir_q;
        if (state_q == S_PROBE_BODY) begin
            det_head = next_head_q;
            det_dir  = dir_q ^ 2'b10;
        end
    end

    always_comb begin
        snake_body_flat = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++)
            snake_body_flat[i*POS_BITS +: POS_BITS] = body_q[i];
    end

    assign snake_head   = body_q[0];
    assign snake_length = len_q;
    assign food_pos     = food_q;
    assign spawn_req    = spawn_req_q;
    assign busy         = busy_q;
    assign game_over    = over_q;
    assign score        = len_q - 7'd1;

endmodule

// File: tb/tb_snake_step_controller.sv
// Bench for snake_step_controller. The bench plays detector and food spawner
// from a reference model that keeps the snake as a list of cells and decides
// wall, self and food hits from x/y grid arithmetic.
module tb_snake_step_controller;

    localparam int ML = 64;
    localparam int PB = 13;

    logic            clk = 1'b0;
    logic            rst, start, tick, pause, det_collision, det_food_eaten, spawn_valid;
    logic [1:0]      dir_req;
    logic [PB-1:0]   spawn_pos;
    logic [PB-1:0]   det_head, snake_head, food_pos;
    logic [1:0]      det_dir;
    logic [ML*PB-1:0] snake_body_flat;
    logic [6:0]      snake_length, score;
    logic            spawn_req, busy, game_over;

    int vecs = 0;
    int errs = 0;

    int m_body[ML];
    int m_len, m_food, m_dir;
    bit m_over;

    snake_step_controller #(
        .MAX_LEN(ML), .POS_BITS(PB), .GRID_W(100), .GRID_H(75),
        .START_POS(3750), .FOOD_INIT(3760)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .dir_req(dir_req),
        .pause(pause), .det_collision(det_collision), .det_food_eaten(det_food_eaten),
        .spawn_valid(spawn_valid), .spawn_pos(spawn_pos), .det_head(det_head),
        .det_dir(det_dir), .snake_head(snake_head), .snake_body_flat(snake_body_flat),
        .snake_length(snake_length), .food_pos(food_pos), .spawn_req(spawn_req),
        .busy(busy), .game_over(game_over), .score(score)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Cell reached by moving one step from p in direction d; -1 if off-grid.
    function automatic int mv(input int p, input int d);
        int x, y;
        x = p % 100;
        y = p / 100;
        case (d)
            0:       return (y == 0)  ? -1 : p - 100;
            1:       return (x == 99) ? -1 : p + 1;
            2:       return (y == 74) ? -1 : p + 100;
            default: return (x == 0)  ? -1 : p - 1;
        endcase
    endfunction

    function automatic bit in_body(input int p);
        for (int i = 0; i < m_len; i++) if (m_body[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    // Spawner: often the cell ahead of the head, otherwise any free cell.
    function automatic int pick_food();
        int c;
        c = mv(m_body[0], m_dir);
        if ($urandom_range(0, 1) == 1 && c >= 0 && !in_body(c)) return c;
        for (int t = 0; t < 50; t++) begin
            c = int'($urandom_range(0, 7499));
            if (!in_body(c)) return c;
        end
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ML; i++) m_body[i] = 0;
        m_body[0] = 3750;
        m_len = 1;
        m_food = 3760;
        m_dir = 1;
        m_over = 1'b0;
    endtask

    task automatic reset_and_start();
        rst = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b0; dir_req = 2'b01;
        det_collision = 1'b0; det_food_eaten = 1'b0; spawn_valid = 1'b0; spawn_pos = '0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_reset();
    endtask

    task automatic restart();
        dir_req = 2'b01;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_reset();
        vecs++;
        if (snake_head !== 13'd3750 || snake_length !== 7'd1 || game_over !== 1'b0 ||
            busy !== 1'b0 || food_pos !== 13'd3760) begin
            errs++;
            $display("FAIL restart head=%0d len=%0d over=%b busy=%b food=%0d expected 3750 1 0 0 3760",
                     snake_head, snake_length, game_over, busy, food_pos);
        end
    endtask

    // One full step. sp_force >= 0 fixes the respawned food cell; leave_wait
    // stops with the DUT parked in WAIT_FOOD.
    task automatic do_step(input logic [1:0] d, input bit hold_tick, input int spawn_delay,
                           input bit force_body, input int sp_force, input bit leave_wait);
        int nxt, sp, rev, old_head, old_len;
        bit selfc, eat, body_bad;
        @(posedge clk); #1;
        dir_req = d;
        tick = 1'b1;
        if (!(m_len > 1 && int'(d) == (m_dir + 2) % 4)) m_dir = int'(d);
        old_head = m_body[0];
        old_len = m_len;

        @(posedge clk); #1;
        if (!hold_tick) tick = 1'b0;
        vecs++;
        if (busy !== 1'b1 || det_head !== PB'(old_head) || det_dir !== 2'(m_dir)) begin
            errs++;
            $display("FAIL probe_wall busy=%b det_head=%0d det_dir=%0d expected 1 %0d %0d",
                     busy, det_head, det_dir, old_head, m_dir);
        end
        nxt = mv(old_head, m_dir);
        det_collision = (nxt < 0);

        @(posedge clk); #1;
        det_collision = 1'b0;
        if (nxt < 0) begin
            tick = 1'b0;
            m_over = 1'b1;
            vecs++;
            if (game_over !== 1'b1 || busy !== 1'b0 || snake_head !== PB'(old_head) ||
                snake_length !== 7'(old_len)) begin
                errs++;
                $display("FAIL wall_over over=%b busy=%b head=%0d len=%0d expected 1 0 %0d %0d",
                         game_over, busy, snake_head, snake_length, old_head, old_len);
            end
            return;
        end

        rev = (m_dir + 2) % 4;
        vecs++;
        if (det_head !== PB'(nxt) || det_dir !== 2'(rev) || busy !== 1'b1) begin
            errs++;
            $display("FAIL probe_body det_head=%0d det_dir=%0d busy=%b expected %0d %0d 1",
                     det_head, det_dir, busy, nxt, rev);
        end
        selfc = in_body(nxt) || force_body;
        eat = !selfc && (nxt == m_food);
        det_collision = selfc;
        det_food_eaten = eat;

        @(posedge clk); #1;
        det_collision = 1'b0;
        det_food_eaten = 1'b0;
        if (selfc) begin
            tick = 1'b0;
            m_over = 1'b1;
            vecs++;
            if (game_over !== 1'b1 || busy !== 1'b0 || snake_head !== PB'(old_head) ||
                snake_length !== 7'(old_len)) begin
                errs++;
                $display("FAIL body_over over=%b busy=%b head=%0d len=%0d expected 1 0 %0d %0d",
                         game_over, busy, snake_head, snake_length, old_head, old_len);
            end
            return;
        end

        vecs++;
        if (busy !== 1'b1 || snake_head !== PB'(old_head)) begin
            errs++;
            $display("FAIL update_phase busy=%b head=%0d expected 1 %0d", busy, snake_head, old_head);
        end
        for (int i = ML - 1; i > 0; i--) m_body[i] = m_body[i-1];
        m_body[0] = nxt;
        if (eat && m_len < ML) m_len++;

        @(posedge clk); #1;
        tick = 1'b0;
        body_bad = 1'b0;
        for (int i = 0; i < m_len; i++)
            if (snake_body_flat[i*PB +: PB] !== PB'(m_body[i])) body_bad = 1'b1;
        vecs++;
        if (body_bad || snake_head !== PB'(nxt) || snake_length !== 7'(m_len) ||
            score !== 7'(m_len - 1) || spawn_req !== eat || busy !== eat || game_over !== 1'b0) begin
            errs++;
            $display("FAIL commit head=%0d len=%0d score=%0d req=%b busy=%b body_bad=%b expected %0d %0d %0d %b %b 0",
                     snake_head, snake_length, score, spawn_req, busy, body_bad,
                     nxt, m_len, m_len - 1, eat, eat);
        end
        if (!eat || leave_wait) return;

        sp = (sp_force >= 0) ? sp_force : pick_food();
        repeat (spawn_delay) @(posedge clk);
        #1;
        vecs++;
        if (spawn_req !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL wait_food req=%b busy=%b expected 1 1", spawn_req, busy);
        end
        spawn_valid = 1'b1;
        spawn_pos = PB'(sp);
        @(posedge clk); #1;
        spawn_valid = 1'b0;
        m_food = sp;
        vecs++;
        if (food_pos !== PB'(sp) || spawn_req !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL respawn food=%0d req=%b busy=%b expected %0d 0 0", food_pos, spawn_req, busy, sp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b0; dir_req = 2'b01;
        det_collision = 1'b0; det_food_eaten = 1'b0; spawn_valid = 1'b0; spawn_pos = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vecs++;
        if (snake_head !== 13'd3750 || snake_length !== 7'd1 || food_pos !== 13'd3760 ||
            det_dir !== 2'b01 || spawn_req !== 1'b0 || busy !== 1'b0 || game_over !== 1'b0 ||
            score !== 7'd0 || snake_body_flat[PB +: PB] !== 13'd0) begin
            errs++;
            $display("FAIL reset head=%0d len=%0d food=%0d dir=%0d req=%b busy=%b over=%b score=%0d",
                     snake_head, snake_length, food_pos, det_dir, spawn_req, busy, game_over, score);
        end
    endtask

    task automatic test_start_tick_same_cycle();
        start = 1'b1; tick = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; tick = 1'b0;
        model_reset();
        @(posedge clk); #1;
        vecs++;
        if (busy !== 1'b0 || snake_head !== 13'd3750) begin
            errs++;
            $display("FAIL start_tick_drop busy=%b head=%0d expected 0 3750", busy, snake_head);
        end
    endtask

    task automatic test_first_step();
        do_step(2'b01, 1'b0, 0, 1'b0, -1, 1'b0);
        vecs++;
        if (snake_head !== 13'd3751 || snake_length !== 7'd1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL first_step head=%0d len=%0d busy=%b expected 3751 1 0",
                     snake_head, snake_length, busy);
        end
    endtask

    task automatic test_grow();
        for (int i = 0; i < 8; i++) do_step(2'b01, 1'b0, 0, 1'b0, -1, 1'b0);
        do_step(2'b01, 1'b0, 3, 1'b0, 500, 1'b0);
        vecs++;
        if (snake_length !== 7'd2 || food_pos !== 13'd500 || spawn_req !== 1'b0 || snake_head !== 13'd3760) begin
            errs++;
            $display("FAIL grow len=%0d food=%0d req=%b head=%0d expected 2 500 0 3760",
                     snake_length, food_pos, spawn_req, snake_head);
        end
    endtask

    task automatic test_dir_reject();
        reset_and_start();
        for (int i = 0; i < 9; i++) do_step(2'b01, 1'b0, 0, 1'b0, 3761, 1'b0);
        do_step(2'b01, 1'b0, 0, 1'b0, 3761, 1'b0);
        do_step(2'b01, 1'b0, 1, 1'b0, 3762, 1'b0);
        do_step(2'b01, 1'b0, 2, 1'b0, 1000, 1'b0);
        do_step(2'b11, 1'b0, 0, 1'b0, -1, 1'b0);
        vecs++;
        if (snake_length !== 7'd4 || snake_head !== 13'd3763 || det_dir !== 2'b01) begin
            errs++;
            $display("FAIL dir_reject len=%0d head=%0d dir=%0d expected 4 3763 1",
                     snake_length, snake_head, det_dir);
        end
        do_step(2'b00, 1'b0, 0, 1'b0, -1, 1'b0);
        vecs++;
        if (snake_head !== 13'd3663 || det_dir !== 2'b00) begin
            errs++;
            $display("FAIL dir_accept head=%0d dir=%0d expected 3663 0", snake_head, det_dir);
        end
    endtask

    task automatic test_wall();
        int n = 0;
        while (!m_over && n < 80) begin
            do_step(2'b00, 1'b0, 0, 1'b0, -1, 1'b0);
            n++;
        end
        vecs++;
        if (!m_over || game_over !== 1'b1 || snake_head >= 13'd100) begin
            errs++;
            $display("FAIL wall_reach over=%b head=%0d steps=%0d expected over on top row",
                     game_over, snake_head, n);
        end
        restart();
    endtask

    task automatic test_body_collision();
        do_step(2'b10, 1'b0, 0, 1'b1, -1, 1'b0);
        vecs++;
        if (game_over !== 1'b1 || snake_head !== 13'd3750) begin
            errs++;
            $display("FAIL body_hit over=%b head=%0d expected 1 3750", game_over, snake_head);
        end
        restart();
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 300; s++) begin
            if (m_over) restart();
            do_step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)), 1'b0, -1, 1'b0);
        end
        if (m_over) restart();
    endtask

    task automatic test_rst_wait_food();
        reset_and_start();
        for (int i = 0; i < 9; i++) do_step(2'b01, 1'b0, 0, 1'b0, -1, 1'b0);
        do_step(2'b01, 1'b0, 0, 1'b0, -1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        vecs++;
        if (spawn_req !== 1'b0 || snake_length !== 7'd1 || busy !== 1'b0 ||
            snake_head !== 13'd3750 || food_pos !== 13'd3760) begin
            errs++;
            $display("FAIL rst_wait_food req=%b len=%0d busy=%b head=%0d food=%0d expected 0 1 0 3750 3760",
                     spawn_req, snake_length, busy, snake_head, food_pos);
        end
        dir_req = 2'b01;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        do_step(2'b01, 1'b0, 0, 1'b0, -1, 1'b0);
    endtask

`ifdef SNAKE_PAUSE_EN
    task automatic test_pause();
        @(posedge clk); #1;
        pause = 1'b1; tick = 1'b1; dir_req = 2'(m_dir ^ 1);
        @(posedge clk); #1;
        tick = 1'b0;
        vecs++;
        if (busy !== 1'b0 || det_dir !== 2'(m_dir)) begin
            errs++;
            $display("FAIL pause busy=%b dir=%0d expected 0 %0d", busy, det_dir, m_dir);
        end
        dir_req = 2'(m_dir);
        pause = 1'b0;
        do_step(2'(m_dir), 1'b0, 0, 1'b0, -1, 1'b0);
        if (m_over) restart();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_start_tick_same_cycle();
        test_first_step();
        test_grow();
        test_dir_reject();
        test_wall();
        test_body_collision();
        test_back_to_back();
        test_rst_wait_food();
`ifdef SNAKE_PAUSE_EN
        test_pause();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
